// File: rtl/bar_fetch_sched.sv
// Per-line fetch scheduler for the shared spectrum magnitude RAM: reads all bars into a
// shadow cache bank each line, swaps banks on the next newline, and arbitrates the FFT writer.
module bar_fetch_sched #(
   parameter int NBARS  = 16,
   parameter int ADDR_W = 4,
   parameter int DATA_W = 10
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              newline,
   input  logic              wr_valid,
   output logic              wr_ready,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   output logic              ram_en,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic [DATA_W-1:0] ram_rdata,
   input  logic [ADDR_W-1:0] bar_idx,
   output logic [DATA_W-1:0] bar_mag,
   output logic              swap,
   output logic              underrun
);

   localparam int IDX_W = (NBARS > 1) ? $clog2(NBARS) : 1;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_FETCH = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   logic [1:0]        state_reg;
   logic [ADDR_W-1:0] cnt_reg;
   logic [IDX_W-1:0]  cap_idx_reg;
   logic              cap_valid_reg;
   logic              active_reg;
   logic              swap_reg;
   logic              underrun_reg;

   logic [DATA_W-1:0] bank0 [NBARS];
   logic [DATA_W-1:0] bank1 [NBARS];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg     <= S_IDLE;
         cnt_reg       <= '0;
         cap_idx_reg   <= '0;
         cap_valid_reg <= 1'b0;
         active_reg    <= 1'b0;
         swap_reg      <= 1'b0;
         underrun_reg  <= 1'b0;
      end else begin
         swap_reg      <= 1'b0;
         underrun_reg  <= 1'b0;
         // Read data returns one cycle later; remember which entry it belongs to.
         cap_valid_reg <= (state_reg == S_FETCH);
         cap_idx_reg   <= cnt_reg[IDX_W-1:0];
         if (newline) begin
            cnt_reg   <= '0;
            state_reg <= S_FETCH;
            case (state_reg)
               S_DONE: begin
                  active_reg <= ~active_reg;
                  swap_reg   <= 1'b1;
               end
               S_FETCH, S_DRAIN: underrun_reg <= 1'b1;
               default: ;
            endcase
         end else begin
            case (state_reg)
               S_FETCH: begin
                  cnt_reg <= cnt_reg + 1'b1;
                  if (cnt_reg == ADDR_W'(NBARS - 1)) state_reg <= S_DRAIN;
               end
               S_DRAIN: state_reg <= S_DONE;
               default: ;
            endcase
         end
      end
   end

   // Shadow bank is always the one not being displayed.
   genvar gi;
   generate
      for (gi = 0; gi < NBARS; gi++) begin : g_entry
         logic [DATA_W-1:0] b0_reg;
         logic [DATA_W-1:0] b1_reg;
         logic              hit;

         assign hit = cap_valid_reg && (cap_idx_reg == IDX_W'(gi));

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               b0_reg <= '0;
               b1_reg <= '0;
            end else if (hit) begin
               if (active_reg) b0_reg <= ram_rdata;
               else            b1_reg <= ram_rdata;
            end
         end

         assign bank0[gi] = b0_reg;
         assign bank1[gi] = b1_reg;
      end
   endgenerate

   always_comb begin
      bar_mag = '0;
      if ({1'b0, bar_idx} < (ADDR_W + 1)'(NBARS))
         bar_mag = active_reg ? bank1[bar_idx[IDX_W-1:0]] : bank0[bar_idx[IDX_W-1:0]];
   end

   // Fetch owns the RAM outright; the writer only gets the leftover cycles.
   always_comb begin
      ram_en    = 1'b0;
      ram_we    = 1'b0;
      ram_addr  = '0;
      ram_wdata = '0;
      if (state_reg == S_FETCH) begin
         ram_en   = 1'b1;
         ram_addr = cnt_reg;
      end else if (wr_valid) begin
         ram_en    = 1'b1;
         ram_we    = 1'b1;
         ram_addr  = wr_addr;
         ram_wdata = wr_data;
      end
   end

   assign wr_ready = (state_reg != S_FETCH);
   assign swap     = swap_reg;
   assign underrun = underrun_reg;

endmodule

// File: tb/tb_bar_fetch_sched.sv
// Directed bench for bar_fetch_sched: fetch sequence, bank swap, writer stall,
// underrun, reset abort, and out-of-range bar index on a wider-address instance.
module tb_bar_fetch_sched;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       newline;
   logic       wr_valid;
   logic       wr_ready;
   logic [3:0] wr_addr;
   logic [9:0] wr_data;
   logic       ram_en, ram_we;
   logic [3:0] ram_addr;
   logic [9:0] ram_wdata;
   logic [9:0] ram_rdata;
   logic [3:0] bar_idx;
   logic [9:0] bar_mag;
   logic       swap, underrun;

   // Second instance with a 5-bit address for the out-of-range index case
   logic       wr_ready5;
   logic       ram_en5, ram_we5;
   logic [4:0] ram_addr5;
   logic [9:0] ram_wdata5;
   logic [9:0] ram_rdata5;
   logic [4:0] bar_idx5;
   logic [9:0] bar_mag5;
   logic       swap5, underrun5;

   logic [9:0] mem [16];
   int         max_addr5 = 0;
   int         nvec = 0;
   int         nmis = 0;
   int         line_no = 0;

   typedef struct {
      logic [3:0] idx;
      int         exp;
   } vec_t;
   vec_t tbl [16];

   always #5 clk = ~clk;

   bar_fetch_sched #(.NBARS(16), .ADDR_W(4), .DATA_W(10)) u_dut (
      .clk(clk), .rst_n(rst_n), .newline(newline),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
      .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
      .ram_rdata(ram_rdata), .bar_idx(bar_idx), .bar_mag(bar_mag),
      .swap(swap), .underrun(underrun)
   );

   bar_fetch_sched #(.NBARS(16), .ADDR_W(5), .DATA_W(10)) u_dut5 (
      .clk(clk), .rst_n(rst_n), .newline(newline),
      .wr_valid(1'b0), .wr_ready(wr_ready5), .wr_addr(5'd0), .wr_data(10'd0),
      .ram_en(ram_en5), .ram_we(ram_we5), .ram_addr(ram_addr5), .ram_wdata(ram_wdata5),
      .ram_rdata(ram_rdata5), .bar_idx(bar_idx5), .bar_mag(bar_mag5),
      .swap(swap5), .underrun(underrun5)
   );

   // Single-port RAM models with one-cycle registered read
   always @(posedge clk) begin
      if (ram_en) begin
         if (ram_we) mem[ram_addr] <= ram_wdata;
         else        ram_rdata <= mem[ram_addr];
      end
      if (ram_en5 && !ram_we5) ram_rdata5 <= 10'(100 + int'(ram_addr5));
   end

   always @(negedge clk) begin
      if (ram_en5 && int'(ram_addr5) > max_addr5) max_addr5 = int'(ram_addr5);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nmis++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   task automatic pulse_nl();
      line_no++;
      $display("line %0d: newline at t=%0t", line_no, $time);
      newline = 1'b1;
      tick();
      newline = 1'b0;
   endtask

   // Called in cycle E+1; returns in cycle E+17 (DRAIN)
   task automatic fetch_seq();
      for (int k = 0; k < 16; k++) begin
         chk("fetch_en", 32'(ram_en), 1);
         chk("fetch_we", 32'(ram_we), 0);
         chk("fetch_addr", 32'(ram_addr), k);
         chk("fetch_wr_ready", 32'(wr_ready), 0);
         if (k > 0) begin
            chk("pulse_swap_low", 32'(swap), 0);
            chk("pulse_underrun_low", 32'(underrun), 0);
         end
         tick();
      end
   endtask

   initial begin
      for (int k = 0; k < 16; k++) begin
         mem[k] = 10'(100 + k);
         tbl[k] = '{idx: 4'(k), exp: 100 + k};
      end
      rst_n = 1'b0; newline = 1'b0; wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
      bar_idx = '0; bar_idx5 = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_bar_mag", 32'(bar_mag), 0);
      chk("rst_wr_ready", 32'(wr_ready), 1);
      chk("rst_ram_en", 32'(ram_en), 0);
      chk("rst_swap", 32'(swap), 0);
      chk("rst_underrun", 32'(underrun), 0);
      rst_n = 1'b1;
      tick(); tick();

      // Line 1: first newline after reset never swaps
      pulse_nl();
      chk("nl1_swap", 32'(swap), 0);
      chk("nl1_underrun", 32'(underrun), 0);
      fetch_seq();
      chk("nl1_drain_wr_ready", 32'(wr_ready), 1);
      repeat (1000) tick();

      // Line 2: swap, writer first offered at E+1 waits for DRAIN
      pulse_nl();
      chk("nl2_swap", 32'(swap), 1);
      chk("nl2_underrun", 32'(underrun), 0);
      wr_valid = 1'b1; wr_addr = 4'd3; wr_data = 10'd999;
      fetch_seq();
      chk("late_wr_ready", 32'(wr_ready), 1);
      chk("late_wr_we", 32'(ram_we), 1);
      chk("late_wr_addr", 32'(ram_addr), 3);
      chk("late_wr_data", 32'(ram_wdata), 999);
      tick();
      wr_valid = 1'b0;
      #1;
      chk("done_ram_idle", 32'(ram_en), 0);
      for (int i = 0; i < 16; i++) begin
         bar_idx = tbl[i].idx;
         #1;
         chk("bar_table", 32'(bar_mag), 32'(tbl[i].exp));
      end
      bar_idx5 = 5'd20;
      #1;
      chk("oor_bar_mag", 32'(bar_mag5), 0);
      bar_idx5 = 5'd5;
      #1;
      chk("wide_bar5", 32'(bar_mag5), 105);
      tick();

      // Line 3: writer offered together with newline is accepted before the fetch
      wr_valid = 1'b1; wr_addr = 4'd3; wr_data = 10'd999; bar_idx = 4'd3;
      #1;
      chk("early_wr_ready", 32'(wr_ready), 1);
      chk("early_wr_we", 32'(ram_we), 1);
      pulse_nl();
      chk("nl3_swap", 32'(swap), 1);
      chk("bar3_before_write", 32'(bar_mag), 103);
      fetch_seq();
      tick();
      wr_valid = 1'b0;
      repeat (5) tick();

      // Line 4: the write is now visible
      pulse_nl();
      chk("nl4_swap", 32'(swap), 1);
      chk("bar3_after_write", 32'(bar_mag), 999);
      fetch_seq();
      tick();

      // Underrun: second newline 10 cycles after the first
      bar_idx = 4'd7;
      pulse_nl();
      chk("nl5_swap", 32'(swap), 1);
      chk("nl5_bar7", 32'(bar_mag), 107);
      repeat (9) tick();
      pulse_nl();
      chk("ur_underrun", 32'(underrun), 1);
      chk("ur_no_swap", 32'(swap), 0);
      chk("ur_bar7", 32'(bar_mag), 107);
      fetch_seq();

      // newline landing in DRAIN still counts as underrun
      pulse_nl();
      chk("drain_underrun", 32'(underrun), 1);
      chk("drain_no_swap", 32'(swap), 0);
      chk("drain_bar7", 32'(bar_mag), 107);
      fetch_seq();
      tick();

      // Reset in the middle of a fetch
      pulse_nl();
      repeat (7) tick();
      chk("pre_rst_fetching", 32'(ram_en), 1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_ram_en", 32'(ram_en), 0);
      chk("mid_rst_wr_ready", 32'(wr_ready), 1);
      chk("mid_rst_bar_mag", 32'(bar_mag), 0);
      chk("mid_rst_swap", 32'(swap), 0);
      tick(); tick();
      rst_n = 1'b1;
      tick();
      pulse_nl();
      chk("post_rst_swap", 32'(swap), 0);
      chk("post_rst_underrun", 32'(underrun), 0);
      fetch_seq();
      tick();

      chk("wide_max_addr", 32'(max_addr5), 15);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end

endmodule
